// File: rtl/sal_bk_ctrl.sv
// Per-bank DRAM command controller: one held request, row-state FSM and bank timing counters.
// Build option SAL_BK_AUTO_PRE_EN selects closed-page policy; without it the bank is open-page.
package sal_bk_pkg;
  typedef logic [13:0] dram_ra_t;
  typedef logic [9:0]  dram_ca_t;
  typedef logic [3:0]  axi_id_t;
  typedef logic [7:0]  axi_len_t;
  typedef logic [7:0]  seq_num_t;
endpackage

module sal_bk_ctrl
  import sal_bk_pkg::*;
#(
  parameter int unsigned TW    = 8,
  parameter int unsigned BK_ID = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_wr_i,
  input  dram_ra_t      req_ra_i,
  input  dram_ca_t      req_ca_i,
  input  axi_id_t       req_id_i,
  input  axi_len_t      req_len_i,
  input  seq_num_t      req_seq_num_i,
  input  logic          ref_pend_i,
  output logic          ref_done_o,
  input  logic [TW-1:0] t_rcd_m1,
  input  logic [TW-1:0] t_rp_m1,
  input  logic [TW-1:0] t_ras_m1,
  input  logic [TW-1:0] t_rtp_m1,
  input  logic [TW-1:0] t_wr_m1,
  input  logic [TW-1:0] t_rfc_m1,
  output logic          act_req_o,
  output logic          rd_req_o,
  output logic          wr_req_o,
  output logic          pre_req_o,
  output logic          ref_req_o,
  output dram_ra_t      ra_o,
  output dram_ca_t      ca_o,
  output axi_id_t       id_o,
  output axi_len_t      len_o,
  output seq_num_t      seq_num_o,
  input  logic          act_gnt_i,
  input  logic          rd_gnt_i,
  input  logic          wr_gnt_i,
  input  logic          pre_gnt_i,
  input  logic          ref_gnt_i
);

  typedef enum logic [2:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING,
    REFRESHING
  } state_t;

  state_t        state, state_d;
  logic          held, held_d, ready_q, hs;
  logic          wr_q;
  dram_ra_t      ra_q, open_row;
  dram_ca_t      ca_q;
  axi_id_t       id_q;
  axi_len_t      len_q;
  seq_num_t      seq_q;
  logic [TW-1:0] trcd_cnt, tras_cnt, trtp_cnt, twr_cnt, trp_cnt, trfc_cnt;
  logic          act_take, rd_take, wr_take, pre_take, ref_take;
  logic          eff_closed, eff_open, row_hit, pre_ok, auto_pre;

`ifdef SAL_BK_AUTO_PRE_EN
  assign auto_pre = 1'b1;
`else
  assign auto_pre = 1'b0;
`endif

  function automatic logic [TW-1:0] cnt_next(input logic load, input logic [TW-1:0] m1,
                                             input logic [TW-1:0] cnt);
    if (load)           return m1;
    else if (cnt != '0) return cnt - TW'(1);
    else                return cnt;
  endfunction

  assign hs          = req_valid_i & ready_q;
  assign req_ready_o = ready_q;
  assign act_take    = act_req_o & act_gnt_i;
  assign rd_take     = rd_req_o  & rd_gnt_i;
  assign wr_take     = wr_req_o  & wr_gnt_i;
  assign pre_take    = pre_req_o & pre_gnt_i;
  assign ref_take    = ref_req_o & ref_gnt_i;
  assign ref_done_o  = ref_take;
  assign held_d      = hs | (held & ~(rd_take | wr_take));

  assign ra_o      = ra_q;
  assign ca_o      = ca_q;
  assign id_o      = id_q;
  assign len_o     = len_q;
  assign seq_num_o = seq_q;

  // A waiting state whose counter has reached zero behaves as its destination in that
  // same cycle, so a command can issue exactly m1+1 cycles after the enabling grant.
  always_comb begin
    state_d    = state;
    act_req_o  = 1'b0;
    rd_req_o   = 1'b0;
    wr_req_o   = 1'b0;
    pre_req_o  = 1'b0;
    ref_req_o  = 1'b0;
    eff_closed = (state == CLOSED) || (state == CLOSING && trp_cnt == '0) ||
                 (state == REFRESHING && trfc_cnt == '0);
    eff_open   = (state == OPEN) || (state == OPENING && trcd_cnt == '0);
    row_hit    = (ra_q == open_row);
    pre_ok     = (tras_cnt == '0) && (trtp_cnt == '0) && (twr_cnt == '0);

    if (eff_closed) begin
      state_d = CLOSED;
      if (ref_pend_i)  ref_req_o = 1'b1;
      else if (held)   act_req_o = 1'b1;
    end else if (eff_open) begin
      state_d = OPEN;
      if (held && !ref_pend_i && row_hit) begin
        rd_req_o = !wr_q;
        wr_req_o = wr_q;
      end else if ((ref_pend_i || held || auto_pre) && pre_ok) begin
        pre_req_o = 1'b1;
      end
    end

    if (!rst_n) begin
      act_req_o = 1'b0;
      rd_req_o  = 1'b0;
      wr_req_o  = 1'b0;
      pre_req_o = 1'b0;
      ref_req_o = 1'b0;
    end

    if (act_req_o && act_gnt_i) state_d = OPENING;
    if (pre_req_o && pre_gnt_i) state_d = CLOSING;
    if (ref_req_o && ref_gnt_i) state_d = REFRESHING;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLOSED;
      held     <= 1'b0;
      ready_q  <= 1'b0;
      open_row <= '0;
      trcd_cnt <= '0;
      tras_cnt <= '0;
      trtp_cnt <= '0;
      twr_cnt  <= '0;
      trp_cnt  <= '0;
      trfc_cnt <= '0;
    end else begin
      state    <= state_d;
      held     <= held_d;
      ready_q  <= ~held_d;
      if (act_take) open_row <= ra_q;
      trcd_cnt <= cnt_next(act_take, t_rcd_m1, trcd_cnt);
      tras_cnt <= cnt_next(act_take, t_ras_m1, tras_cnt);
      trtp_cnt <= cnt_next(rd_take,  t_rtp_m1, trtp_cnt);
      twr_cnt  <= cnt_next(wr_take,  t_wr_m1,  twr_cnt);
      trp_cnt  <= cnt_next(pre_take, t_rp_m1,  trp_cnt);
      trfc_cnt <= cnt_next(ref_take, t_rfc_m1, trfc_cnt);
    end
  end

  // Payload is only observed while held is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (hs) begin
      wr_q  <= req_wr_i;
      ra_q  <= req_ra_i;
      ca_q  <= req_ca_i;
      id_q  <= req_id_i;
      len_q <= req_len_i;
      seq_q <= req_seq_num_i;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o}))
    else $error("sal_bk_ctrl[%0d]: more than one command request", BK_ID);

  assert property (@(posedge clk) disable iff (!rst_n)
    !((act_gnt_i && !act_req_o) || (rd_gnt_i && !rd_req_o) || (wr_gnt_i && !wr_req_o) ||
      (pre_gnt_i && !pre_req_o) || (ref_gnt_i && !ref_req_o)))
    else $error("sal_bk_ctrl[%0d]: grant without matching request", BK_ID);

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Bench for sal_bk_ctrl: timestamp-based bank model checked every cycle plus directed timing checks.
`timescale 1ns/1ps
module tb_sal_bk_ctrl;
  import sal_bk_pkg::*;

  localparam int unsigned TW = 8;
`ifdef SAL_BK_AUTO_PRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk, rst_n;
  logic req_valid_i, req_ready_o, req_wr_i;
  dram_ra_t req_ra_i, ra_o;
  dram_ca_t req_ca_i, ca_o;
  axi_id_t  req_id_i, id_o;
  axi_len_t req_len_i, len_o;
  seq_num_t req_seq_num_i, seq_num_o;
  logic ref_pend_i, ref_done_o;
  logic [TW-1:0] t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wr_m1, t_rfc_m1;
  logic act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o;
  logic act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i;

  sal_bk_ctrl #(.TW(TW), .BK_ID(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_ra_i(req_ra_i), .req_ca_i(req_ca_i), .req_id_i(req_id_i), .req_len_i(req_len_i),
    .req_seq_num_i(req_seq_num_i), .ref_pend_i(ref_pend_i), .ref_done_o(ref_done_o),
    .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1), .t_rtp_m1(t_rtp_m1),
    .t_wr_m1(t_wr_m1), .t_rfc_m1(t_rfc_m1),
    .act_req_o(act_req_o), .rd_req_o(rd_req_o), .wr_req_o(wr_req_o), .pre_req_o(pre_req_o),
    .ref_req_o(ref_req_o), .ra_o(ra_o), .ca_o(ca_o), .id_o(id_o), .len_o(len_o),
    .seq_num_o(seq_num_o), .act_gnt_i(act_gnt_i), .rd_gnt_i(rd_gnt_i), .wr_gnt_i(wr_gnt_i),
    .pre_gnt_i(pre_gnt_i), .ref_gnt_i(ref_gnt_i)
  );

  int errors = 0, checks = 0, cyc = 0;
  int cap_ra, cap_ca, last_pre_cyc = -1, pre_count = 0, done_count = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scheduler stand-in: grants whatever the bank requests, mid-cycle.
  initial begin
    {act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i} = '0;
    forever begin
      @(posedge clk); #3;
      act_gnt_i = act_req_o; rd_gnt_i = rd_req_o; wr_gnt_i = wr_req_o;
      pre_gnt_i = pre_req_o; ref_gnt_i = ref_req_o;
    end
  end

  // Bank model: row state plus the cycle numbers at which each timing constraint is met.
  bit m_held, m_wr, m_open, m_rst_last;
  int m_ra, m_ca, m_id, m_len, m_seq, m_row;
  int m_avail, m_ras_ok, m_rtp_ok, m_wr_ok;
  bit e_act, e_rd, e_wr, e_pre, e_ref, e_ready, e_done;

  initial begin : compare
    m_held = 0; m_wr = 0; m_open = 0; m_rst_last = 1; m_row = 0;
    m_ra = 0; m_ca = 0; m_id = 0; m_len = 0; m_seq = 0;
    m_avail = 0; m_ras_ok = 0; m_rtp_ok = 0; m_wr_ok = 0;
    forever begin
      @(posedge clk); #4;
      {e_act, e_rd, e_wr, e_pre, e_ref} = '0;
      e_ready = !m_held && !m_rst_last;
      if (rst_n && cyc >= m_avail) begin
        if (!m_open) begin
          if (ref_pend_i) e_ref = 1;
          else if (m_held) e_act = 1;
        end else if (m_held && !ref_pend_i && m_ra == m_row) begin
          e_rd = !m_wr;
          e_wr = m_wr;
        end else if ((ref_pend_i || m_held || AUTO) &&
                     cyc >= m_ras_ok && cyc >= m_rtp_ok && cyc >= m_wr_ok) begin
          e_pre = 1;
        end
      end
      e_done = e_ref && ref_gnt_i;
      chk("req_ready", req_ready_o, e_ready);
      chk("act_req", act_req_o, e_act);
      chk("rd_req", rd_req_o, e_rd);
      chk("wr_req", wr_req_o, e_wr);
      chk("pre_req", pre_req_o, e_pre);
      chk("ref_req", ref_req_o, e_ref);
      chk("ref_done", ref_done_o, e_done);
      if (e_act) chk("ra_o", ra_o, m_ra);
      if (e_rd || e_wr) begin
        chk("ca_o", ca_o, m_ca);
        chk("id_o", id_o, m_id);
        chk("len_o", len_o, m_len);
        chk("seq_num_o", seq_num_o, m_seq);
      end
      if (pre_req_o) begin last_pre_cyc = cyc; pre_count++; end
      if (ref_done_o) done_count++;

      if (!rst_n) begin
        m_held = 0; m_open = 0; m_rst_last = 1;
        m_avail = 0; m_ras_ok = 0; m_rtp_ok = 0; m_wr_ok = 0;
      end else begin
        m_rst_last = 0;
        if (e_act && act_gnt_i) begin
          m_open = 1; m_row = m_ra;
          m_avail = cyc + int'(t_rcd_m1) + 1;
          m_ras_ok = cyc + int'(t_ras_m1) + 1;
        end
        if (e_rd && rd_gnt_i) begin m_held = 0; m_rtp_ok = cyc + int'(t_rtp_m1) + 1; end
        if (e_wr && wr_gnt_i) begin m_held = 0; m_wr_ok = cyc + int'(t_wr_m1) + 1; end
        if (e_pre && pre_gnt_i) begin m_open = 0; m_avail = cyc + int'(t_rp_m1) + 1; end
        if (e_ref && ref_gnt_i) m_avail = cyc + int'(t_rfc_m1) + 1;
        if (req_valid_i && e_ready) begin
          m_held = 1; m_wr = req_wr_i; m_ra = int'(req_ra_i); m_ca = int'(req_ca_i);
          m_id = int'(req_id_i); m_len = int'(req_len_i); m_seq = int'(req_seq_num_i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic bit cmd_hi(input int kind);
    case (kind)
      0:       return act_req_o;
      1:       return rd_req_o;
      2:       return wr_req_o;
      3:       return pre_req_o;
      default: return ref_req_o;
    endcase
  endfunction

  // Offer one request; returns the cycle in which the handshake occurred.
  task automatic offer(input bit wr, input int ra, input int ca, input int seq, output int hcyc);
    req_wr_i = wr; req_ra_i = dram_ra_t'(ra); req_ca_i = dram_ca_t'(ca);
    req_id_i = axi_id_t'(seq + 1); req_len_i = axi_len_t'(seq * 2 + 1);
    req_seq_num_i = seq_num_t'(seq); req_valid_i = 1'b1;
    hcyc = -1;
    for (int i = 0; i < 20 && hcyc < 0; i++) begin
      #1;
      if (req_ready_o) hcyc = cyc;
      tick();
    end
    req_valid_i = 1'b0;
    if (hcyc < 0) chk("offer_timeout", 0, 1);
  endtask

  // Wait for a command request (0 ACT, 1 RD, 2 WR, 3 PRE, 4 REF); returns its cycle.
  task automatic wait_cmd(input int kind, output int c);
    c = -1;
    for (int i = 0; i < 40 && c < 0; i++) begin
      #1;
      if (cmd_hi(kind)) begin c = cyc; cap_ra = int'(ra_o); cap_ca = int'(ca_o); end
      tick();
    end
    if (c < 0) chk($sformatf("wait_cmd%0d_timeout", kind), 0, 1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick();
    #1;
    chk("reset_ready", req_ready_o, 0);
    chk("reset_reqs", {act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o, ref_done_o}, 0);
    repeat (n - 1) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : main
    int h, g, r, p, a, c, rf, snap;
    rst_n = 1'b0; req_valid_i = 1'b0; req_wr_i = 1'b0; req_ra_i = '0; req_ca_i = '0;
    req_id_i = '0; req_len_i = '0; req_seq_num_i = '0; ref_pend_i = 1'b0;
    t_rcd_m1 = 8'd2; t_rp_m1 = 8'd2; t_ras_m1 = 8'd2;
    t_rtp_m1 = 8'd2; t_wr_m1 = 8'd2; t_rfc_m1 = 8'd2;
    tick();

    // Read to row 5 from reset: ACT next cycle, RD three cycles after the ACT grant.
    do_reset(3);
    #1;
    chk("ready_after_reset", req_ready_o, 1);
    offer(1'b0, 5, 'h33, 1, h);
    wait_cmd(0, g);
    chk("act_cycle", g, h + 1);
    chk("act_row", cap_ra, 5);
    wait_cmd(1, r);
    chk("rd_after_act", r - g, 3);
    chk("rd_col", cap_ca, 'h33);
    #1;
    chk("ready_after_rd", req_ready_o, 1);

    // Write hit on the open row.
    offer(1'b1, 5, 'h44, 2, h);
    wait_cmd(2, c);
`ifndef SAL_BK_AUTO_PRE_EN
    chk("wr_hit_cycle", c, h + 1);
`endif
    chk("wr_col", cap_ca, 'h44);
    #1;
    chk("ready_after_wr", req_ready_o, 1);

    // Row miss with a long tRAS: PRE waits for tRAS, ACT waits for tRP.
    t_ras_m1 = 8'd6;
    do_reset(2);
    offer(1'b0, 5, 'h10, 3, h);
    wait_cmd(0, g);
    wait_cmd(1, r);
    chk("rd_row5", r, g + 3);
    offer(1'b0, 9, 'h20, 4, h);
    wait_cmd(3, p);
    chk("pre_after_tras", p, g + 7);
    wait_cmd(0, a);
    chk("act_after_trp", a, p + 3);
    chk("act_row9", cap_ra, 9);
    wait_cmd(1, r);
    chk("rd_row9", r, a + 3);
    chk("rd_row9_col", cap_ca, 'h20);

    // Refresh while open with a request held: PRE, REF, one ref_done, then ACT.
    repeat (6) tick();
    snap = done_count;
    ref_pend_i = 1'b1;
    offer(1'b1, 9, 'h30, 5, h);
    wait_cmd(4, rf);
    ref_pend_i = 1'b0;
`ifndef SAL_BK_AUTO_PRE_EN
    chk("pre_on_ref_cycle", last_pre_cyc, h);
    chk("ref_after_trp", rf, last_pre_cyc + 3);
`endif
    wait_cmd(0, a);
    chk("act_after_trfc", a, rf + 3);
    chk("act_after_ref_row", cap_ra, 9);
    wait_cmd(2, c);
    chk("wr_after_ref", c, a + 3);
    chk("ref_done_pulses", done_count - snap, 1);

    // Page policy after a single read.
    t_ras_m1 = 8'd2;
    do_reset(2);
    offer(1'b0, 3, 'h11, 6, h);
    wait_cmd(0, g);
    wait_cmd(1, r);
`ifdef SAL_BK_AUTO_PRE_EN
    wait_cmd(3, p);
    chk("auto_pre_at_trtp", p, r + 3);
`else
    snap = pre_count;
    repeat (100) tick();
    chk("no_pre_when_idle", pre_count - snap, 0);
`endif

    // Reset pulse while OPENING drops the request and returns to CLOSED.
    do_reset(2);
    offer(1'b0, 7, 'h22, 7, h);
    wait_cmd(0, g);
    rst_n = 1'b0;
    tick();
    #1;
    chk("mid_reset_reqs", {act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o}, 0);
    chk("mid_reset_ready", req_ready_o, 0);
    rst_n = 1'b1;
    tick();
    #1;
    chk("ready_after_mid_reset", req_ready_o, 1);
    chk("held_dropped", act_req_o, 0);
    offer(1'b0, 7, 'h23, 8, h);
    wait_cmd(0, a);
    chk("act_from_closed", a, h + 1);
    wait_cmd(1, r);
    chk("rd_after_mid_reset", r, a + 3);
    chk("rd_after_mid_reset_col", cap_ca, 'h23);

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #60000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
